// File: rtl/accelerator_sequencer_pkg.sv
// Shared types and helpers for the tensor operand sequencer.
package accelerator_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } seq_state_t;

  localparam logic SINGLE    = 1'b0;
  localparam logic BROADCAST = 1'b1;

  // One bit of the channel mask: set for every channel in broadcast,
  // otherwise only for the selected channel.
  function automatic logic channel_mask_bit(input logic mode,
                                            input logic [31:0] sel,
                                            input logic [31:0] ch);
    return (mode == BROADCAST) || (sel == ch);
  endfunction

endpackage

// File: rtl/accelerator_index_counter.sv
// Two-level wrap counter: j walks a row, i advances when j wraps.
module accelerator_index_counter
  import accelerator_sequencer_pkg::*;
#(
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_advance,
  input  logic [CONTROL_SIZE-1:0] i_size_i,
  input  logic [CONTROL_SIZE-1:0] i_size_j,
  output logic [CONTROL_SIZE-1:0] o_i,
  output logic [CONTROL_SIZE-1:0] o_j,
  output logic                    o_last,
  output logic                    o_row_start
);

  localparam logic [CONTROL_SIZE-1:0] ZERO = {CONTROL_SIZE{1'b0}};
  localparam logic [CONTROL_SIZE-1:0] ONE  = {{(CONTROL_SIZE-1){1'b0}}, 1'b1};

  logic [CONTROL_SIZE-1:0] r_i;
  logic [CONTROL_SIZE-1:0] r_j;
  logic                    w_j_wrap;
  logic                    w_i_wrap;

  assign w_j_wrap    = (r_j == (i_size_j - ONE));
  assign w_i_wrap    = (r_i == (i_size_i - ONE));
  assign o_i         = r_i;
  assign o_j         = r_j;
  assign o_last      = w_i_wrap & w_j_wrap;
  assign o_row_start = (r_j == ZERO);

  // Advance j on every accepted element; wrap j and step i at row end.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_i <= ZERO;
      r_j <= ZERO;
    end else if (i_advance) begin
      if (w_j_wrap) begin
        r_j <= ZERO;
        r_i <= w_i_wrap ? ZERO : (r_i + ONE);
      end else begin
        r_j <= r_j + ONE;
      end
    end
  end

endmodule

// File: rtl/accelerator_tensor_sequencer.sv
// Generic two-level operand sequencer: streams a SIZE_I x SIZE_J job to
// one operand channel or to all channels, with outer/inner strobes.
module accelerator_tensor_sequencer
  import accelerator_sequencer_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int CHANNELS     = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        MODE,
  input  logic [$clog2(CHANNELS)-1:0] CHANNEL_SELECT,
  input  logic [DATA_SIZE-1:0]        SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]        SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]        DATA_IN,
  input  logic                        DATA_IN_VALID,
  output logic                        DATA_IN_READY,
  input  logic                        STALL,
  output logic [DATA_SIZE-1:0]        DATA_OUT,
  output logic [CHANNELS-1:0]         I_ENABLE,
  output logic [CHANNELS-1:0]         J_ENABLE,
  output logic [CONTROL_SIZE-1:0]     I_INDEX,
  output logic [CONTROL_SIZE-1:0]     J_INDEX,
  output logic                        BUSY,
  output logic                        READY
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [CONTROL_SIZE-1:0] CZERO = {CONTROL_SIZE{1'b0}};

  seq_state_t                r_state;
  seq_state_t                w_state_next;
  logic                      r_mode;
  logic [SEL_W-1:0]          r_sel;
  logic [CONTROL_SIZE-1:0]   r_size_i;
  logic [CONTROL_SIZE-1:0]   r_size_j;
  logic [DATA_SIZE-1:0]      r_data;
  logic [CHANNELS-1:0]       r_i_en;
  logic [CHANNELS-1:0]       r_j_en;
  logic [CONTROL_SIZE-1:0]   r_i_index;
  logic [CONTROL_SIZE-1:0]   r_j_index;
  logic                      r_busy;
  logic                      r_ready;

  logic [CONTROL_SIZE-1:0]   w_size_i_in;
  logic [CONTROL_SIZE-1:0]   w_size_j_in;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_start_ok;
  logic                      w_start_zero;
  logic [CHANNELS-1:0]       w_mask;
  logic [CONTROL_SIZE-1:0]   w_cnt_i;
  logic [CONTROL_SIZE-1:0]   w_cnt_j;
  logic                      w_last;
  logic                      w_row_start;

  // Only the low CONTROL_SIZE bits of the requested sizes matter.
  assign w_size_i_in = SIZE_I_IN[CONTROL_SIZE-1:0];
  assign w_size_j_in = SIZE_J_IN[CONTROL_SIZE-1:0];

  assign w_in_ready    = (r_state == STREAM) & ~STALL;
  assign w_accept      = w_in_ready & DATA_IN_VALID;
  assign DATA_IN_READY = w_in_ready;

  assign DATA_OUT = r_data;
  assign I_ENABLE = r_i_en;
  assign J_ENABLE = r_j_en;
  assign I_INDEX  = r_i_index;
  assign J_INDEX  = r_j_index;
  assign BUSY     = r_busy;
  assign READY    = r_ready;

  accelerator_index_counter #(
    .CONTROL_SIZE(CONTROL_SIZE)
  ) u_index_counter (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_clear     (w_start_ok),
    .i_advance   (w_accept),
    .i_size_i    (r_size_i),
    .i_size_j    (r_size_j),
    .o_i         (w_cnt_i),
    .o_j         (w_cnt_j),
    .o_last      (w_last),
    .o_row_start (w_row_start)
  );

  // Target channel mask from the latched mode and channel select.
  always_comb begin
    w_mask = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      w_mask[c] = channel_mask_bit(r_mode, 32'(r_sel), 32'(c));
    end
  end

  // Next state: start a job on a non-empty START, finish on the last accept.
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_start_zero = 1'b0;
    case (r_state)
      IDLE: begin
        if (START) begin
          if ((w_size_i_in != CZERO) && (w_size_j_in != CZERO)) begin
            w_state_next = STREAM;
            w_start_ok   = 1'b1;
          end else begin
            w_start_zero = 1'b1;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      STREAM: begin
        if (w_accept && w_last) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = STREAM;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, configuration latch and registered element/strobe outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_sel     <= {SEL_W{1'b0}};
      r_size_i  <= CZERO;
      r_size_j  <= CZERO;
      r_data    <= {DATA_SIZE{1'b0}};
      r_i_en    <= {CHANNELS{1'b0}};
      r_j_en    <= {CHANNELS{1'b0}};
      r_i_index <= CZERO;
      r_j_index <= CZERO;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == STREAM);
      if (w_start_ok || w_start_zero) begin
        r_mode   <= MODE;
        r_sel    <= CHANNEL_SELECT;
        r_size_i <= w_size_i_in;
        r_size_j <= w_size_j_in;
      end
      if (w_accept) begin
        r_data    <= DATA_IN;
        r_i_index <= w_cnt_i;
        r_j_index <= w_cnt_j;
        r_j_en    <= w_mask;
        r_i_en    <= w_row_start ? w_mask : {CHANNELS{1'b0}};
        r_ready   <= w_last;
      end else begin
        r_j_en  <= {CHANNELS{1'b0}};
        r_i_en  <= {CHANNELS{1'b0}};
        r_ready <= w_start_zero;
      end
    end
  end

endmodule
